zx_mem_pager: RTL and testbench

Parametrised memory pager for the ZX Spectrum host board, the 128K-class successor to the fixed 48K address map. It sits between the A-Z80 bus and the flash/SRAM/video-RAM back ends. It holds the 0x7FFD paging register with its lock bit and translates every CPU address into a physical ROM or SRAM address. It also inserts a programmable number of wait states on SRAM accesses.

---
 rtl/zx_pkg.sv | 33 +++
 rtl/zx_wait_gen.sv | 75 +++++++
 rtl/zx_mem_pager.sv | 131 +++++++++++++
 tb/tb_zx_mem_pager.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_pkg.sv
// Shared types and constants for the ZX Spectrum 128K-class memory pager.
// Holds the bus region / wait-FSM encodings and the 0x7FFD port decode helper.
package zx_pkg;

  typedef enum logic [1:0] {
    REGION_ROM  = 2'd0,
    REGION_SRAM = 2'd1,
    REGION_IDLE = 2'd2
  } region_t;

  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_WAIT = 2'd1,
    WS_HOLD = 2'd2
  } wait_state_t;

  localparam logic [15:0] PAGE_PORT = 16'h7FFD;
  localparam logic [4:0]  BANK_4000 = 5'd5;
  localparam logic [4:0]  BANK_8000 = 5'd2;
  localparam int          LOCK_BIT  = 5;

  // Partial decode matches the original 128K machine: A15 and A1 both low.
  function automatic logic port_hit(input logic [15:0] a, input logic full_decode);
    logic hit;
    if (full_decode) begin
      hit = (a == PAGE_PORT);
    end else begin
      hit = (a[15] == 1'b0) && (a[1] == 1'b0);
    end
    return hit;
  endfunction

endpackage

// File: rtl/zx_wait_gen.sv
// SRAM wait-state generator: pulls nWAIT low for WAIT_STATES cycles after an
// SRAM access is seen, then holds until MREQ is released.
module zx_wait_gen
  import zx_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic nMREQ,
  input  logic sram_sel,
  output logic nWAIT
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES - 1);
  localparam logic       WS_EN    = (WAIT_STATES > 0);

  wait_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        nwait_q, nwait_d;

  // Next-state, counter and nWAIT computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WS_IDLE: begin
        if (!nMREQ && sram_sel && WS_EN) begin
          state_d = WS_WAIT;
          cnt_d   = 3'd0;
        end else begin
          state_d = WS_IDLE;
        end
      end
      WS_WAIT: begin
        // An aborted access drops straight back to idle.
        if (nMREQ) begin
          state_d = WS_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = WS_HOLD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WS_HOLD: begin
        if (nMREQ) begin
          state_d = WS_IDLE;
        end else begin
          state_d = WS_HOLD;
        end
      end
      default: begin
        state_d = WS_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    nwait_d = (state_d != WS_WAIT);
  end

  // State, counter and registered nWAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WS_IDLE;
      cnt_q   <= 3'd0;
      nwait_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nwait_q <= nwait_d;
    end
  end

  assign nWAIT = nwait_q;

endmodule

// File: rtl/zx_mem_pager.sv
// 128K-class memory pager: 0x7FFD paging register with lock, CPU-to-physical
// ROM/SRAM address translation and SRAM wait-state insertion.
module zx_mem_pager
  import zx_pkg::*;
#(
  parameter int RAM_BANKS   = 8,
  parameter int ROM_PAGES   = 2,
  parameter int SRAM_AW     = 18,
  parameter int ROM_AW      = 22,
  parameter int WAIT_STATES = 0,
  parameter int FULL_DECODE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        A,
  input  logic [7:0]         D,
  input  logic               nMREQ,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  input  logic               nM1,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [1:0]         region,
  output logic               sram_we,
  output logic               nWAIT,
  output logic               screen_sel,
  output logic [7:0]         page_reg,
  output logic               locked
);

  localparam int BANK_W = $clog2(RAM_BANKS);
  localparam int ROM_W  = $clog2(ROM_PAGES);

  if (ROM_PAGES == 4 && RAM_BANKS == 32) begin : g_bad_cfg
    $error("zx_mem_pager: ROM_PAGES=4 cannot be combined with RAM_BANKS=32");
  end
  if (SRAM_AW < 14 + BANK_W) begin : g_bad_aw
    $error("zx_mem_pager: SRAM_AW too small for RAM_BANKS");
  end

  logic [7:0]        page_reg_q, page_reg_d;
  logic              locked_q, locked_d;
  logic              iow_q, iow_d;
  logic              iow_s, load_s;
  logic [4:0]        bank_paged_s;
  logic [1:0]        rom_sel_s;
  logic [BANK_W-1:0] bank_s;
  logic [ROM_W-1:0]  rom_page_s;
  logic              sram_sel_s;
  region_t           region_s;
  logic              bus_unused_s;

  assign iow_s  = !nIORQ && !nWR && port_hit(A, FULL_DECODE != 0) && nM1;
  assign load_s = iow_s && !iow_q && !locked_q;

  // Paging register update on the rising edge of the I/O write strobe.
  always_comb begin
    page_reg_d = page_reg_q;
    locked_d   = locked_q;
    iow_d      = iow_s;
    if (load_s) begin
      page_reg_d = D;
      locked_d   = locked_q | D[LOCK_BIT];
    end else begin
      page_reg_d = page_reg_q;
      locked_d   = locked_q;
    end
  end

  // Paging register, lock and strobe history.
  always_ff @(posedge clk) begin
    if (reset) begin
      page_reg_q <= 8'h00;
      locked_q   <= 1'b0;
      iow_q      <= 1'b0;
    end else begin
      page_reg_q <= page_reg_d;
      locked_q   <= locked_d;
      iow_q      <= iow_d;
    end
  end

  // Pentagon high bits sit above bits 2:0; truncation masks to the bank count.
  assign bank_paged_s = {page_reg_q[7:6], page_reg_q[2:0]};
  assign rom_sel_s    = {page_reg_q[7], page_reg_q[4]};
  assign rom_page_s   = rom_sel_s[ROM_W-1:0];
  assign sram_sel_s   = (A[15:14] != 2'b00);

  // Bank selection per 16K window.
  always_comb begin
    bank_s = {BANK_W{1'b0}};
    case (A[15:14])
      2'b01:   bank_s = BANK_W'(BANK_4000);
      2'b10:   bank_s = BANK_W'(BANK_8000);
      2'b11:   bank_s = bank_paged_s[BANK_W-1:0];
      default: bank_s = {BANK_W{1'b0}};
    endcase
  end

  // Access target decode.
  always_comb begin
    region_s = REGION_IDLE;
    if (!nMREQ) begin
      region_s = sram_sel_s ? REGION_SRAM : REGION_ROM;
    end else begin
      region_s = REGION_IDLE;
    end
  end

  assign sram_addr  = SRAM_AW'({bank_s, A[13:0]});
  assign rom_addr   = ROM_AW'({rom_page_s, A[13:0]});
  assign region     = region_s;
  assign sram_we    = !nMREQ && !nWR && sram_sel_s;
  assign page_reg   = page_reg_q;
  assign locked     = locked_q;
  assign screen_sel = page_reg_q[3];

  assign bus_unused_s = ^{nRD, bank_paged_s, rom_sel_s};

  zx_wait_gen #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_gen (
    .clk     (clk),
    .reset   (reset),
    .nMREQ   (nMREQ),
    .sram_sel(sram_sel_s),
    .nWAIT   (nWAIT)
  );

endmodule

// File: tb/tb_zx_mem_pager.sv
// Scoreboard bench for zx_mem_pager: two instances (8 banks / partial decode /
// 3 wait states, and 32 banks / full decode / no wait states) share one bus.
module tb_zx_mem_pager;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nMREQ, nIORQ, nRD, nWR, nM1;

  logic [21:0] rom_addr_a, rom_addr_b;
  logic [17:0] sram_addr_a;
  logic [18:0] sram_addr_b;
  logic [1:0]  region_a, region_b;
  logic        sram_we_a, sram_we_b, nwait_a, nwait_b;
  logic        screen_a, screen_b, locked_a, locked_b;
  logic [7:0]  page_a, page_b;

  always #5 clk = ~clk;

  zx_mem_pager #(
    .RAM_BANKS(8), .ROM_PAGES(2), .SRAM_AW(18), .ROM_AW(22),
    .WAIT_STATES(3), .FULL_DECODE(0)
  ) u_a (
    .clk(clk), .reset(reset), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .rom_addr(rom_addr_a), .sram_addr(sram_addr_a), .region(region_a),
    .sram_we(sram_we_a), .nWAIT(nwait_a), .screen_sel(screen_a),
    .page_reg(page_a), .locked(locked_a)
  );

  zx_mem_pager #(
    .RAM_BANKS(32), .ROM_PAGES(2), .SRAM_AW(19), .ROM_AW(22),
    .WAIT_STATES(0), .FULL_DECODE(1)
  ) u_b (
    .clk(clk), .reset(reset), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .rom_addr(rom_addr_b), .sram_addr(sram_addr_b), .region(region_b),
    .sram_we(sram_we_b), .nWAIT(nwait_b), .screen_sel(screen_b),
    .page_reg(page_b), .locked(locked_b)
  );

  localparam int S_A_SRAM = 0, S_A_ROM = 1, S_A_REGION = 2, S_A_WE = 3,
                 S_A_NWAIT = 4, S_A_SCREEN = 5, S_A_PAGE = 6, S_A_LOCK = 7,
                 S_B_SRAM = 8, S_B_PAGE = 9, S_B_NWAIT = 10, S_B_LOCK = 11,
                 S_B_REGION = 12;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_A_SRAM:   return 32'(sram_addr_a);
      S_A_ROM:    return 32'(rom_addr_a);
      S_A_REGION: return 32'(region_a);
      S_A_WE:     return 32'(sram_we_a);
      S_A_NWAIT:  return 32'(nwait_a);
      S_A_SCREEN: return 32'(screen_a);
      S_A_PAGE:   return 32'(page_a);
      S_A_LOCK:   return 32'(locked_a);
      S_B_SRAM:   return 32'(sram_addr_b);
      S_B_PAGE:   return 32'(page_b);
      S_B_NWAIT:  return 32'(nwait_b);
      S_B_LOCK:   return 32'(locked_b);
      S_B_REGION: return 32'(region_b);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c   = sb.pop_front();
      act = actual(c.sel);
      n_checks++;
      if (act !== c.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [31:0] v);
    sb.push_back('{name, sel, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  task automatic mem_rd(input logic [15:0] a);
    bus_idle();
    A = a; nMREQ = 1'b0; nRD = 1'b0;
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
    bus_idle();
    A = a; D = d; nMREQ = 1'b0; nWR = 1'b0;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    bus_idle();
    A = a; D = d; nIORQ = 1'b0; nWR = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A = 16'h0000; D = 8'h00;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset defaults, with an SRAM read that is aborted inside WAIT.
    mem_rd(16'hC000);
    chk("rst_region", S_A_REGION, 32'd1);
    chk("rst_sram",   S_A_SRAM,   32'h0_0000);
    chk("rst_page",   S_A_PAGE,   32'h00);
    chk("rst_lock",   S_A_LOCK,   32'd0);
    chk("rst_screen", S_A_SCREEN, 32'd0);
    chk("rst_nwait",  S_A_NWAIT,  32'd1);
    chk("rst_b_sram", S_B_SRAM,   32'h0_0000);
    tick();
    bus_idle();
    chk("abort_wait_low", S_A_NWAIT,  32'd0);
    chk("idle_region",    S_A_REGION, 32'd2);
    chk("idle_we",        S_A_WE,     32'd0);
    tick();
    chk("abort_release", S_A_NWAIT, 32'd1);
    tick();
    chk("abort_idle", S_A_NWAIT, 32'd1);

    // Bank 7, ROM 1, screen 7; iow held two edges with D changing.
    io_wr(16'h7FFD, 8'h1F);
    chk("old_map_page", S_A_PAGE, 32'h00);
    tick();
    chk("p1f_page",   S_A_PAGE,   32'h1F);
    chk("p1f_screen", S_A_SCREEN, 32'd1);
    chk("p1f_b_page", S_B_PAGE,   32'h1F);
    D = 8'h00;
    tick();
    chk("held_once_a", S_A_PAGE, 32'h1F);
    chk("held_once_b", S_B_PAGE, 32'h1F);
    bus_idle();
    tick();

    // SRAM read in bank 7 with 3 wait states on instance A.
    mem_rd(16'hC123);
    chk("c123_sram",   S_A_SRAM,  32'h1_C123);
    chk("c123_b_sram", S_B_SRAM,  32'h1_C123);
    chk("ws_c0",       S_A_NWAIT, 32'd1);
    tick(); chk("ws_c1", S_A_NWAIT, 32'd0);
    tick(); chk("ws_c2", S_A_NWAIT, 32'd0);
    tick(); chk("ws_c3", S_A_NWAIT, 32'd0);
    chk("b_no_wait", S_B_NWAIT, 32'd1);
    tick(); chk("ws_hold1", S_A_NWAIT, 32'd1);
    tick(); chk("ws_hold2", S_A_NWAIT, 32'd1);
    bus_idle();
    tick(); chk("ws_after", S_A_NWAIT, 32'd1);

    // ROM read: page 1, no wait states.
    mem_rd(16'h0100);
    chk("rom_addr",   S_A_ROM,    32'h4100);
    chk("rom_region", S_A_REGION, 32'd0);
    tick(); chk("rom_nwait1", S_A_NWAIT, 32'd1);
    tick(); chk("rom_nwait2", S_A_NWAIT, 32'd1);

    // SRAM write into bank 2 window.
    mem_wr(16'h8005, 8'hAA);
    chk("wr_we",     S_A_WE,     32'd1);
    chk("wr_sram",   S_A_SRAM,   32'h0_8005);
    chk("b_region",  S_B_REGION, 32'd1);
    tick();
    bus_idle();
    tick();

    // Lock: second write must be ignored; reset clears.
    io_wr(16'h7FFD, 8'h23);
    tick();
    chk("lock_page",   S_A_PAGE,   32'h23);
    chk("lock_set",    S_A_LOCK,   32'd1);
    chk("lock_screen", S_A_SCREEN, 32'd0);
    bus_idle();
    tick();
    io_wr(16'h7FFD, 8'h07);
    tick();
    bus_idle();
    tick();
    chk("locked_page",   S_A_PAGE, 32'h23);
    chk("locked_flag",   S_A_LOCK, 32'd1);
    chk("locked_b_page", S_B_PAGE, 32'h23);
    chk("locked_b_flag", S_B_LOCK, 32'd1);
    reset = 1'b1;
    tick();
    chk("unlock_page", S_A_PAGE, 32'h00);
    chk("unlock_flag", S_A_LOCK, 32'd0);
    reset = 1'b0;

    // Partial vs full decode, and M1 blocking the strobe.
    io_wr(16'h3FFD, 8'h05);
    tick();
    chk("partial_hit", S_A_PAGE, 32'h05);
    chk("full_miss",   S_B_PAGE, 32'h00);
    bus_idle();
    tick();
    io_wr(16'h7FFD, 8'h06);
    nM1 = 1'b0;
    tick();
    chk("m1_blocks", S_A_PAGE, 32'h05);
    bus_idle();
    tick();

    // 32-bank high bits on B; 8-bank wrap on A.
    io_wr(16'h7FFD, 8'hC3);
    tick();
    chk("c3_b_page", S_B_PAGE, 32'hC3);
    bus_idle();
    tick();
    mem_rd(16'hC000);
    chk("bank27_sram", S_B_SRAM, 32'h6_C000);
    chk("wrap_a_sram", S_A_SRAM, 32'h0_C000);

    // Reset during WAIT.
    tick();
    chk("rw_wait", S_A_NWAIT, 32'd0);
    reset = 1'b1;
    tick();
    chk("rw_nwait", S_A_NWAIT, 32'd1);
    chk("rw_page",  S_A_PAGE,  32'h00);
    reset = 1'b0;
    bus_idle();
    tick();
    chk("rw_idle", S_A_NWAIT, 32'd1);

    // Reset wins over a simultaneous port write.
    reset = 1'b1;
    io_wr(16'h7FFD, 8'h11);
    tick();
    chk("rst_wins_a", S_A_PAGE, 32'h00);
    chk("rst_wins_b", S_B_PAGE, 32'h00);
    reset = 1'b0;
    bus_idle();
    tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d checks left unprocessed, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
